const_enc_tone_mapper: RTL

//  Parametrised tone-ordering bit extractor and QAM mapper for the ADSL DMT transmitter (G.992.1).
//  Per DMT symbol it walks the tone-ordered table and pulls b bits per tone.
//  The first FastBits bits of the symbol come from the fast-path byte stream, the rest from the interleaved stream.

---
 rtl/const_enc_tone_mapper.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/const_enc_tone_mapper.sv
// Tone-ordered bit extractor and QAM mapper for the ADSL DMT transmit path.
// Per symbol it walks the tone table, pulls b bits per tone from the fast then interleaved stream, and emits (x,y).
module const_enc_tone_mapper #(
  parameter int DW       = 8,
  parameter int TABLELEN = 256,
  parameter int CNUMW    = 8,
  parameter int MAXB     = 14,
  parameter int CONSTW   = 9,
  parameter int CONFAW   = 10,
  parameter int CONFDW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fast_valid_i,
  input  logic [DW-1:0]            fast_data_i,
  output logic                     fast_ready_o,
  input  logic                     inter_valid_i,
  input  logic [DW-1:0]            inter_data_i,
  output logic                     inter_ready_o,
  input  logic [CONFAW-1:0]        addr_i,
  input  logic                     we_conf_i,
  input  logic [CONFDW-1:0]        conf_data_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     sym_done_o,
  output logic                     cfg_err_o,
  output logic                     xy_valid_o,
  input  logic                     xy_ready_i,
  output logic [CNUMW-1:0]         carrier_num_o,
  output logic signed [CONSTW-1:0] x_o,
  output logic signed [CONSTW-1:0] y_o
);

  localparam int AW   = (TABLELEN > 1) ? $clog2(TABLELEN) : 1;
  localparam int UCW  = $clog2(TABLELEN + 1);
  localparam int ACCW = MAXB + DW - 1;
  localparam int CW   = $clog2(ACCW + 1);
  localparam int BW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_MAP, S_OUT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [UCW-1:0]            idx_q, idx_d;
  logic [CONFDW-1:0]         fast_rem_q, fast_rem_d;
  logic [BW-1:0]             b_q, b_d;
  logic [BW-1:0]             nf_q, nf_d;
  logic [BW-1:0]             ni_q, ni_d;
  logic [ACCW-1:0]           fast_acc_q, fast_acc_d;
  logic [ACCW-1:0]           inter_acc_q, inter_acc_d;
  logic [CW-1:0]             fast_cnt_q, fast_cnt_d;
  logic [CW-1:0]             inter_cnt_q, inter_cnt_d;
  logic                      fast_rdy_q, fast_rdy_d;
  logic                      inter_rdy_q, inter_rdy_d;
  logic                      busy_q, busy_d;
  logic                      sym_done_q, sym_done_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      xy_valid_q, xy_valid_d;
  logic [CNUMW-1:0]          carrier_q, carrier_d;
  logic signed [CONSTW-1:0]  x_q, x_d;
  logic signed [CONSTW-1:0]  y_q, y_d;
  logic [UCW-1:0]            used_carrier_q, used_carrier_d;
  logic [CONFDW-1:0]         fast_bits_q, fast_bits_d;

  // Tables survive reset, so they live outside the reset domain.
  logic [3:0]                bl_mem [TABLELEN];
  logic [CNUMW-1:0]          cn_mem [TABLELEN];

  logic                      cfg_wr, bl_we, cn_we;
  logic [CONFAW-1:0]         cn_off;
  logic [AW-1:0]             tbl_idx;
  logic [3:0]                rd_bl;
  logic [CNUMW-1:0]          rd_cn;
  logic [ACCW-1:0]           fast_mask, inter_mask, tone_cat;
  logic [MAXB-1:0]           tone_v;
  logic                      unused_bits;

  function automatic logic [BW-1:0] clip_bits(input logic [3:0] raw);
    int unsigned e;
    e = int'(raw) & 32'hFFFF_FFFE;
    if (e > MAXB) e = MAXB;
    return BW'(e);
  endfunction

  function automatic logic bad_bits(input logic [3:0] raw);
    return raw[0] || (int'(raw) > MAXB);
  endfunction

  // odd=1 gathers v[1],v[3],.. (x); odd=0 gathers v[0],v[2],.. (y); LSB forced to 1.
  function automatic logic signed [CONSTW-1:0] fold_axis(input logic [MAXB-1:0] v,
                                                         input logic [BW-1:0] b,
                                                         input logic odd);
    logic signed [CONSTW-1:0] r;
    int h;
    h = int'(b) / 2;
    r = '0;
    if (h != 0) begin
      r[0] = 1'b1;
      for (int k = 0; k < MAXB / 2; k++) begin
        if (k < h) r[k+1] = odd ? v[2*k+1] : v[2*k];
      end
      for (int k = 1; k < CONSTW; k++) begin
        if (k > h) r[k] = r[k-1];
      end
    end
    return r;
  endfunction

  assign cfg_wr = we_conf_i && !busy_q;
  assign bl_we  = cfg_wr && (addr_i < CONFAW'(TABLELEN));
  assign cn_we  = cfg_wr && (addr_i >= CONFAW'(TABLELEN)) && (addr_i < CONFAW'(2 * TABLELEN));
  assign cn_off = addr_i - CONFAW'(TABLELEN);

  always_ff @(posedge clk) begin
    if (bl_we) bl_mem[addr_i[AW-1:0]] <= conf_data_i[3:0];
    if (cn_we) cn_mem[cn_off[AW-1:0]] <= conf_data_i[CNUMW-1:0];
  end

  always_comb begin
    used_carrier_d = used_carrier_q;
    fast_bits_d    = fast_bits_q;
    if (cfg_wr && addr_i == CONFAW'(2 * TABLELEN))     used_carrier_d = conf_data_i[UCW-1:0];
    if (cfg_wr && addr_i == CONFAW'(2 * TABLELEN + 1)) fast_bits_d    = conf_data_i;
  end

  assign tbl_idx = idx_q[AW-1:0];
  assign rd_bl   = bl_mem[tbl_idx];
  assign rd_cn   = cn_mem[tbl_idx];

  // Fast bits occupy the low end of v, interleaved bits sit above them.
  assign fast_mask  = (ACCW'(1) << nf_q) - ACCW'(1);
  assign inter_mask = (ACCW'(1) << ni_q) - ACCW'(1);
  assign tone_cat   = (fast_acc_q & fast_mask) | ((inter_acc_q & inter_mask) << nf_q);
  assign tone_v     = tone_cat[MAXB-1:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fast_rem_d  = fast_rem_q;
    b_d         = b_q;
    nf_d        = nf_q;
    ni_d        = ni_q;
    fast_acc_d  = fast_acc_q;
    inter_acc_d = inter_acc_q;
    fast_cnt_d  = fast_cnt_q;
    inter_cnt_d = inter_cnt_q;
    cfg_err_d   = cfg_err_q;
    xy_valid_d  = xy_valid_q;
    carrier_d   = carrier_q;
    x_d         = x_q;
    y_d         = y_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d      = '0;
          fast_rem_d = fast_bits_q;
          state_d    = (used_carrier_q == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        b_d = clip_bits(rd_bl);
        if (bad_bits(rd_bl)) cfg_err_d = 1'b1;
        if (CONFDW'(b_d) <= fast_rem_q) nf_d = b_d;
        else                            nf_d = fast_rem_q[BW-1:0];
        ni_d    = b_d - nf_d;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (fast_rdy_q && fast_valid_i) begin
          fast_acc_d = fast_acc_q | (ACCW'(fast_data_i) << fast_cnt_q);
          fast_cnt_d = fast_cnt_q + CW'(DW);
        end
        if (inter_rdy_q && inter_valid_i) begin
          inter_acc_d = inter_acc_q | (ACCW'(inter_data_i) << inter_cnt_q);
          inter_cnt_d = inter_cnt_q + CW'(DW);
        end
        if (fast_cnt_q >= CW'(nf_q) && inter_cnt_q >= CW'(ni_q)) state_d = S_MAP;
      end
      S_MAP: begin
        x_d         = fold_axis(tone_v, b_q, 1'b1);
        y_d         = fold_axis(tone_v, b_q, 1'b0);
        carrier_d   = rd_cn;
        xy_valid_d  = 1'b1;
        fast_acc_d  = fast_acc_q >> nf_q;
        fast_cnt_d  = fast_cnt_q - CW'(nf_q);
        inter_acc_d = inter_acc_q >> ni_q;
        inter_cnt_d = inter_cnt_q - CW'(ni_q);
        fast_rem_d  = fast_rem_q - CONFDW'(nf_q);
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (xy_ready_i) begin
          xy_valid_d = 1'b0;
          idx_d      = idx_q + UCW'(1);
          state_d    = (idx_q + UCW'(1) == used_carrier_q) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        // Leftover bits of a partly used byte never carry into the next symbol.
        fast_acc_d  = '0;
        inter_acc_d = '0;
        fast_cnt_d  = '0;
        inter_cnt_d = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it is computed from the next-cycle state and counts.
    fast_rdy_d  = (state_d == S_FILL) && (fast_cnt_d < CW'(nf_d)) &&
                  (int'(fast_cnt_d) + DW <= ACCW);
    inter_rdy_d = (state_d == S_FILL) && (inter_cnt_d < CW'(ni_d)) &&
                  (int'(inter_cnt_d) + DW <= ACCW);
    busy_d      = (state_d != S_IDLE);
    sym_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      fast_rem_q     <= '0;
      b_q            <= '0;
      nf_q           <= '0;
      ni_q           <= '0;
      fast_acc_q     <= '0;
      inter_acc_q    <= '0;
      fast_cnt_q     <= '0;
      inter_cnt_q    <= '0;
      fast_rdy_q     <= 1'b0;
      inter_rdy_q    <= 1'b0;
      busy_q         <= 1'b0;
      sym_done_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      xy_valid_q     <= 1'b0;
      carrier_q      <= '0;
      x_q            <= '0;
      y_q            <= '0;
      used_carrier_q <= '0;
      fast_bits_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      fast_rem_q     <= fast_rem_d;
      b_q            <= b_d;
      nf_q           <= nf_d;
      ni_q           <= ni_d;
      fast_acc_q     <= fast_acc_d;
      inter_acc_q    <= inter_acc_d;
      fast_cnt_q     <= fast_cnt_d;
      inter_cnt_q    <= inter_cnt_d;
      fast_rdy_q     <= fast_rdy_d;
      inter_rdy_q    <= inter_rdy_d;
      busy_q         <= busy_d;
      sym_done_q     <= sym_done_d;
      cfg_err_q      <= cfg_err_d;
      xy_valid_q     <= xy_valid_d;
      carrier_q      <= carrier_d;
      x_q            <= x_d;
      y_q            <= y_d;
      used_carrier_q <= used_carrier_d;
      fast_bits_q    <= fast_bits_d;
    end
  end

  assign fast_ready_o  = fast_rdy_q;
  assign inter_ready_o = inter_rdy_q;
  assign busy_o        = busy_q;
  assign sym_done_o    = sym_done_q;
  assign cfg_err_o     = cfg_err_q;
  assign xy_valid_o    = xy_valid_q;
  assign carrier_num_o = carrier_q;
  assign x_o           = x_q;
  assign y_o           = y_q;

  assign unused_bits = ^{cn_off, tone_cat, conf_data_i};

endmodule
